// File: rtl/conversor_bcd_binario.sv
// Iterative BCD-to-binary converter (reverse double-dabble): one shift or one
// digit correction per clock, with invalid-digit detection at start.
module conversor_bcd_binario #(
    parameter int DIGITOS_DECIMAIS = 4,
    parameter int LARGURA_SAIDA    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DIGITOS_DECIMAIS*4-1:0] entrada_bcd,
    input  logic                          iniciar,
    output logic [LARGURA_SAIDA-1:0]      saida_binaria,
    output logic                          dados_validos,
    output logic                          ocupado,
    output logic                          erro_digito
);

    localparam int BW = DIGITOS_DECIMAIS * 4;
    localparam int CW = (LARGURA_SAIDA > 1) ? $clog2(LARGURA_SAIDA) : 1;
    localparam int IW = (DIGITOS_DECIMAIS > 1) ? $clog2(DIGITOS_DECIMAIS) : 1;

    typedef enum logic [2:0] {
        S_OCIOSO                 = 3'd0,
        S_DESLOCA                = 3'd1,
        S_VERIFICA_INDICE_DESLOC = 3'd2,
        S_SUBTRAI_3              = 3'd3,
        S_VERIFICA_INDICE_DIGITO = 3'd4,
        S_CONCLUIDO              = 3'd5
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [BW-1:0]     bcd_reg_q, bcd_reg_d;
    logic [LARGURA_SAIDA-1:0] bin_reg_q, bin_reg_d;
    logic [CW-1:0]     contador_loop_q, contador_loop_d;
    logic [IW-1:0]     indice_digito_q, indice_digito_d;
    logic              erro_reg_q, erro_reg_d;
    logic              dados_validos_reg_q, dados_validos_reg_d;
    logic              entrada_invalida;

    always_comb begin
        entrada_invalida = 1'b0;
        for (int unsigned i = 0; i < DIGITOS_DECIMAIS; i++) begin
            if (entrada_bcd[4*i +: 4] > 4'd9) entrada_invalida = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q            <= S_OCIOSO;
            bcd_reg_q           <= '0;
            bin_reg_q           <= '0;
            contador_loop_q     <= '0;
            indice_digito_q     <= '0;
            erro_reg_q          <= 1'b0;
            dados_validos_reg_q <= 1'b0;
        end else begin
            estado_q            <= estado_d;
            bcd_reg_q           <= bcd_reg_d;
            bin_reg_q           <= bin_reg_d;
            contador_loop_q     <= contador_loop_d;
            indice_digito_q     <= indice_digito_d;
            erro_reg_q          <= erro_reg_d;
            dados_validos_reg_q <= dados_validos_reg_d;
        end
    end

    always_comb begin
        estado_d            = estado_q;
        bcd_reg_d           = bcd_reg_q;
        bin_reg_d           = bin_reg_q;
        contador_loop_d     = contador_loop_q;
        indice_digito_d     = indice_digito_q;
        erro_reg_d          = erro_reg_q;
        dados_validos_reg_d = 1'b0;

        case (estado_q)
            S_OCIOSO: begin
                if (iniciar) begin
                    bcd_reg_d       = entrada_bcd;
                    bin_reg_d       = '0;
                    contador_loop_d = '0;
                    indice_digito_d = '0;
                    erro_reg_d      = entrada_invalida;
                    estado_d        = entrada_invalida ? S_CONCLUIDO : S_DESLOCA;
                end
            end
            S_DESLOCA: begin
                bin_reg_d = {bcd_reg_q[0], bin_reg_q[LARGURA_SAIDA-1:1]};
                bcd_reg_d = {1'b0, bcd_reg_q[BW-1:1]};
                estado_d  = S_VERIFICA_INDICE_DESLOC;
            end
            S_VERIFICA_INDICE_DESLOC: begin
                if (contador_loop_q == CW'(LARGURA_SAIDA - 1)) begin
                    contador_loop_d = '0;
                    estado_d        = S_CONCLUIDO;
                end else begin
                    contador_loop_d = contador_loop_q + CW'(1);
                    estado_d        = S_SUBTRAI_3;
                end
            end
            S_SUBTRAI_3: begin
                // Nibble in 8..15 maps to 5..12, so no borrow leaves the digit
                for (int unsigned i = 0; i < DIGITOS_DECIMAIS; i++) begin
                    if (indice_digito_q == IW'(i) && bcd_reg_q[4*i +: 4] >= 4'd8)
                        bcd_reg_d[4*i +: 4] = bcd_reg_q[4*i +: 4] - 4'd3;
                end
                estado_d = S_VERIFICA_INDICE_DIGITO;
            end
            S_VERIFICA_INDICE_DIGITO: begin
                if (indice_digito_q == IW'(DIGITOS_DECIMAIS - 1)) begin
                    indice_digito_d = '0;
                    estado_d        = S_DESLOCA;
                end else begin
                    indice_digito_d = indice_digito_q + IW'(1);
                    estado_d        = S_SUBTRAI_3;
                end
            end
            S_CONCLUIDO: begin
                dados_validos_reg_d = 1'b1;
                estado_d            = S_OCIOSO;
            end
            default: estado_d = S_OCIOSO;
        endcase
    end

    assign saida_binaria = bin_reg_q;
    assign dados_validos = dados_validos_reg_q;
    assign erro_digito   = erro_reg_q;
    assign ocupado       = (estado_q != S_OCIOSO);

endmodule

// File: tb/tb_conversor_bcd_binario.sv
// Directed bench for conversor_bcd_binario: default 4-digit/16-bit instance
// plus a 5-digit/17-bit instance for the wide case.
module tb_conversor_bcd_binario;

    logic        clk;
    logic        reset_n;

    logic [15:0] entrada1;
    logic        iniciar1;
    logic [15:0] saida1;
    logic        dv1, ocup1, erro1;

    logic [19:0] entrada2;
    logic        iniciar2;
    logic [16:0] saida2;
    logic        dv2, ocup2, erro2;

    int checks;
    int fails;

    conversor_bcd_binario #(.DIGITOS_DECIMAIS(4), .LARGURA_SAIDA(16)) dut1 (
        .clk(clk), .reset_n(reset_n), .entrada_bcd(entrada1), .iniciar(iniciar1),
        .saida_binaria(saida1), .dados_validos(dv1), .ocupado(ocup1), .erro_digito(erro1)
    );

    conversor_bcd_binario #(.DIGITOS_DECIMAIS(5), .LARGURA_SAIDA(17)) dut2 (
        .clk(clk), .reset_n(reset_n), .entrada_bcd(entrada2), .iniciar(iniciar2),
        .saida_binaria(saida2), .dados_validos(dv2), .ocupado(ocup2), .erro_digito(erro2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges until dados_validos is seen high (bounded by limite)
    task automatic wait_dv1(input int limite, output int n);
        n = 0;
        do begin
            @(posedge clk); n++; #1;
        end while (!dv1 && n < limite);
    endtask

    task automatic wait_dv2(input int limite, output int n);
        n = 0;
        do begin
            @(posedge clk); n++; #1;
        end while (!dv2 && n < limite);
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        iniciar1 = 1'b0; entrada1 = '0;
        iniciar2 = 1'b0; entrada2 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (saida1 !== 16'h0) begin fails++; $display("FAIL reset_saida1 got %h exp 0000", saida1); end
        checks++; if (dv1 !== 1'b0) begin fails++; $display("FAIL reset_dv1 got %b exp 0", dv1); end
        checks++; if (ocup1 !== 1'b0) begin fails++; $display("FAIL reset_ocup1 got %b exp 0", ocup1); end
        checks++; if (erro1 !== 1'b0) begin fails++; $display("FAIL reset_erro1 got %b exp 0", erro1); end
        checks++; if (saida2 !== 17'h0) begin fails++; $display("FAIL reset_saida2 got %h exp 0", saida2); end
        checks++; if ({dv2, ocup2, erro2} !== 3'b000) begin fails++; $display("FAIL reset_flags2 got %b exp 000", {dv2, ocup2, erro2}); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int n;
        entrada1 = 16'h1234; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        checks++; if (ocup1 !== 1'b1) begin fails++; $display("FAIL basic_ocupado_start got %b exp 1", ocup1); end
        wait_dv1(400, n);
        checks++; if (n !== 153) begin fails++; $display("FAIL basic_latency got %0d exp 153", n); end
        checks++; if (saida1 !== 16'h04D2) begin fails++; $display("FAIL basic_result got %h exp 04d2", saida1); end
        checks++; if (erro1 !== 1'b0) begin fails++; $display("FAIL basic_erro got %b exp 0", erro1); end
        checks++; if (ocup1 !== 1'b0) begin fails++; $display("FAIL basic_ocupado_done got %b exp 0", ocup1); end
        @(posedge clk); #1;
        checks++; if (dv1 !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b exp 0", dv1); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (saida1 !== 16'h04D2) begin fails++; $display("FAIL basic_result_hold got %h exp 04d2", saida1); end
    endtask

    task automatic test_back_to_back;
        int n;
        entrada1 = 16'h9999; iniciar1 = 1'b1;
        @(posedge clk); #1;
        entrada1 = 16'h0000;
        wait_dv1(400, n);
        checks++; if (n !== 153) begin fails++; $display("FAIL b2b_latency1 got %0d exp 153", n); end
        checks++; if (saida1 !== 16'h270F) begin fails++; $display("FAIL b2b_result1 got %h exp 270f", saida1); end
        @(posedge clk); #1;
        checks++; if (ocup1 !== 1'b1) begin fails++; $display("FAIL b2b_second_accept got %b exp 1", ocup1); end
        checks++; if (dv1 !== 1'b0) begin fails++; $display("FAIL b2b_dv_drop got %b exp 0", dv1); end
        repeat (10) @(posedge clk);
        #1;
        iniciar1 = 1'b0;
        wait_dv1(400, n);
        checks++; if (n !== 143) begin fails++; $display("FAIL b2b_latency2 got %0d exp 143", n); end
        checks++; if (saida1 !== 16'h0000) begin fails++; $display("FAIL b2b_result2 got %h exp 0000", saida1); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ocup1 !== 1'b0) begin fails++; $display("FAIL b2b_no_extra_start got %b exp 0", ocup1); end
    endtask

    task automatic test_invalid_digit;
        int n;
        entrada1 = 16'h12A4; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        checks++; if (ocup1 !== 1'b1) begin fails++; $display("FAIL inv_ocupado got %b exp 1", ocup1); end
        wait_dv1(400, n);
        checks++; if (n !== 1) begin fails++; $display("FAIL inv_latency got %0d exp 1", n); end
        checks++; if (saida1 !== 16'h0000) begin fails++; $display("FAIL inv_result got %h exp 0000", saida1); end
        checks++; if (erro1 !== 1'b1) begin fails++; $display("FAIL inv_erro got %b exp 1", erro1); end
        entrada1 = 16'h0042; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        checks++; if (erro1 !== 1'b0) begin fails++; $display("FAIL inv_erro_clear got %b exp 0", erro1); end
        wait_dv1(400, n);
        checks++; if (n !== 153) begin fails++; $display("FAIL inv_next_latency got %0d exp 153", n); end
        checks++; if (saida1 !== 16'h002A) begin fails++; $display("FAIL inv_next_result got %h exp 002a", saida1); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_while_busy;
        int n;
        entrada1 = 16'h0777; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        entrada1 = 16'hFFFF; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        wait_dv1(400, n);
        checks++; if (n !== 103) begin fails++; $display("FAIL busy_latency got %0d exp 103", n); end
        checks++; if (saida1 !== 16'h0309) begin fails++; $display("FAIL busy_result got %h exp 0309", saida1); end
        checks++; if (erro1 !== 1'b0) begin fails++; $display("FAIL busy_erro got %b exp 0", erro1); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ocup1 !== 1'b0) begin fails++; $display("FAIL busy_not_queued got %b exp 0", ocup1); end
    endtask

    task automatic test_reset_abort;
        int n;
        bit visto;
        entrada1 = 16'h1234; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        repeat (69) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (saida1 !== 16'h0) begin fails++; $display("FAIL abort_saida got %h exp 0000", saida1); end
        checks++; if ({dv1, ocup1, erro1} !== 3'b000) begin fails++; $display("FAIL abort_flags got %b exp 000", {dv1, ocup1, erro1}); end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        visto = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (dv1) visto = 1'b1;
        end
        checks++; if (visto !== 1'b0) begin fails++; $display("FAIL abort_no_pulse got %b exp 0", visto); end
        entrada1 = 16'h0500; iniciar1 = 1'b1;
        @(posedge clk); #1;
        iniciar1 = 1'b0;
        wait_dv1(400, n);
        checks++; if (n !== 153) begin fails++; $display("FAIL abort_next_latency got %0d exp 153", n); end
        checks++; if (saida1 !== 16'h01F4) begin fails++; $display("FAIL abort_next_result got %h exp 01f4", saida1); end
    endtask

    task automatic test_wide;
        int n;
        entrada2 = 20'h99999; iniciar2 = 1'b1;
        @(posedge clk); #1;
        iniciar2 = 1'b0;
        wait_dv2(500, n);
        checks++; if (n !== 195) begin fails++; $display("FAIL wide_latency got %0d exp 195", n); end
        checks++; if (saida2 !== 17'h1869F) begin fails++; $display("FAIL wide_result got %h exp 1869f", saida2); end
        checks++; if (erro2 !== 1'b0) begin fails++; $display("FAIL wide_erro got %b exp 0", erro2); end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_invalid_digit;
        test_ignore_while_busy;
        test_reset_abort;
        test_wide;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
